// File: rtl/s5_pkg.sv
// Shared constants and the 1-resilient [5,4,2] compression function for the
// TRNG post-processing stage.
package s5_pkg;

  localparam int S5_IN_W  = 5;
  localparam int S5_OUT_W = 4;
  localparam int BYTE_W   = 8;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  // Each output bit mixes one data bit with the parity bit d[4], so no single
  // fixed input bit can bias any output value.
  function automatic logic [S5_OUT_W-1:0] s5_f(input logic [S5_IN_W-1:0] d);
    return d[S5_OUT_W-1:0] ^ {S5_OUT_W{d[S5_IN_W-1]}};
  endfunction

endpackage

// File: rtl/nibble_byte_packer.sv
// Packs successive nibbles into bytes, low nibble first; a reset discards any
// half-filled byte.
module nibble_byte_packer
  import s5_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              NIB_VALID,
  input  logic [S5_OUT_W-1:0] NIB_IN,
  output logic              BYTE_VALID,
  output logic [BYTE_W-1:0] BYTE_OUT
);

  phase_e              phase_q, phase_d;
  logic [S5_OUT_W-1:0] low_q, low_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                bvalid_q, bvalid_d;

  always_comb begin
    phase_d  = phase_q;
    low_d    = low_q;
    byte_d   = byte_q;
    bvalid_d = 1'b0;
    if (NIB_VALID) begin
      case (phase_q)
        PH_LOW: begin
          low_d   = NIB_IN;
          phase_d = PH_HIGH;
        end
        PH_HIGH: begin
          byte_d   = {NIB_IN, low_q};
          bvalid_d = 1'b1;
          phase_d  = PH_LOW;
        end
        default: phase_d = PH_LOW;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q  <= PH_LOW;
      low_q    <= '0;
      byte_q   <= '0;
      bvalid_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      low_q    <= low_d;
      byte_q   <= byte_d;
      bvalid_q <= bvalid_d;
    end
  end

  assign BYTE_VALID = bvalid_q;
  assign BYTE_OUT   = byte_q;

endmodule

// File: rtl/s5_resilient_map.sv
// TRNG post-processing: 5-bit raw sample -> registered 4-bit resilient nibble,
// plus byte packing of consecutive nibbles.
module s5_resilient_map
  import s5_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  input  logic [S5_IN_W-1:0]  D_IN,
  output logic                OUT_VALID,
  output logic [S5_OUT_W-1:0] D_OUT,
  output logic                BYTE_VALID,
  output logic [BYTE_W-1:0]   BYTE_OUT
);

  // Valid-only handshake: a sample is taken on every edge with IN_VALID=1;
  // OUT_VALID/BYTE_VALID are single-cycle pulses and the consumer never stalls.
  logic [S5_OUT_W-1:0] nib_d;
  logic [S5_OUT_W-1:0] d_out_q;
  logic                out_valid_q;

  assign nib_d = s5_f(D_IN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      d_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= IN_VALID;
      if (IN_VALID) d_out_q <= nib_d;
    end
  end

  assign D_OUT     = d_out_q;
  assign OUT_VALID = out_valid_q;

  // Fed from the same combinational nibble so BYTE_VALID lines up with OUT_VALID.
  nibble_byte_packer u_packer (
    .CLK        (CLK),
    .RST        (RST),
    .NIB_VALID  (IN_VALID),
    .NIB_IN     (nib_d),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_OUT   (BYTE_OUT)
  );

endmodule

// File: tb/tb_s5_resilient_map.sv
// Scoreboard bench for s5_resilient_map: per-cycle expected records are queued
// by the driver and compared by a monitor after each rising edge.
module tb_s5_resilient_map;
  import s5_pkg::*;

  // clock / reset block
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_VALID = 1'b0;
  logic [4:0] D_IN = '0;
  logic       OUT_VALID;
  logic [3:0] D_OUT;
  logic       BYTE_VALID;
  logic [7:0] BYTE_OUT;

  always #5 CLK = ~CLK;

  s5_resilient_map dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .D_IN       (D_IN),
    .OUT_VALID  (OUT_VALID),
    .D_OUT      (D_OUT),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_OUT   (BYTE_OUT)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // record: [19] sweep, [18:14] din, [13] ov, [12:9] d_out, [8] bv, [7:0] byte
  logic [19:0] exp_q[$];

  // reference state of the stage, derived from the golden function
  logic [3:0] m_dout  = '0;
  logic [7:0] m_byte  = '0;
  logic       m_phase = 1'b0;
  logic [3:0] m_low   = '0;

  int hist[16];
  int fixc[5][2][16];
  int byte_cnt = 0;

  initial begin
    for (int n = 0; n < 16; n++) begin
      hist[n] = 0;
      for (int b = 0; b < 5; b++) begin
        fixc[b][0][n] = 0;
        fixc[b][1][n] = 0;
      end
    end
  end

  // driver: apply inputs for the next edge, queue what that edge must produce
  task automatic step(input logic rst, input logic v, input logic [4:0] din, input logic sweep);
    logic ov, bv;
    logic [3:0] nib;
    RST = rst;
    IN_VALID = v;
    D_IN = din;
    ov = 1'b0;
    bv = 1'b0;
    if (rst) begin
      m_dout = '0; m_byte = '0; m_phase = 1'b0; m_low = '0;
    end else if (v) begin
      nib = s5_f(din);
      m_dout = nib;
      ov = 1'b1;
      if (!m_phase) begin
        m_low = nib;
        m_phase = 1'b1;
      end else begin
        m_byte = {nib, m_low};
        m_phase = 1'b0;
        bv = 1'b1;
      end
    end
    exp_q.push_back({sweep, din, ov, m_dout, bv, m_byte});
    @(posedge CLK);
    #1;
  endtask

  // monitor / scoreboard
  logic [19:0] mon_rec;
  always @(posedge CLK) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_rec = exp_q.pop_front();
      check("out_valid",  OUT_VALID,  mon_rec[13]);
      check("d_out",      D_OUT,      mon_rec[12:9]);
      check("byte_valid", BYTE_VALID, mon_rec[8]);
      check("byte_out",   BYTE_OUT,   mon_rec[7:0]);
      if (mon_rec[19] && OUT_VALID) begin
        hist[D_OUT]++;
        for (int b = 0; b < 5; b++) fixc[b][mon_rec[14+b]][D_OUT]++;
      end
      if (mon_rec[19] && BYTE_VALID) byte_cnt++;
    end
  end

  logic [4:0] spot_in[6]  = '{5'd0, 5'd16, 5'd5, 5'd21, 5'd31, 5'd1};
  logic [3:0] spot_exp[6] = '{4'h0, 4'hF, 4'h5, 4'hA, 4'h0, 4'h1};

  initial begin
    // reset held two cycles while a valid sample is offered
    step(1'b1, 1'b1, 5'd21, 1'b0);
    step(1'b1, 1'b1, 5'd21, 1'b0);
    check("rst_dout", D_OUT, 4'h0);
    check("rst_byte", BYTE_OUT, 8'h00);
    check("rst_ov", OUT_VALID, 1'b0);
    check("rst_bv", BYTE_VALID, 1'b0);

    // spot values against fixed constants
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, spot_in[i], 1'b0);
      check("spot_dout", D_OUT, spot_exp[i]);
      check("spot_ov", OUT_VALID, 1'b1);
    end

    // packing 21 then 1
    step(1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 5'd21, 1'b0);
    check("pack_first_bv", BYTE_VALID, 1'b0);
    step(1'b0, 1'b1, 5'd1, 1'b0);
    check("pack_1A", BYTE_OUT, 8'h1A);
    check("pack_bv", BYTE_VALID, 1'b1);
    check("pack_ov", OUT_VALID, 1'b1);

    // exhaustive sweep, back to back
    step(1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 5'(i), 1'b1);
      if (i == 1) check("sweep_first_byte", BYTE_OUT, 8'h10);
    end
    step(1'b0, 1'b0, 5'd0, 1'b0);
    check("sweep_bytes", byte_cnt, 16);
    for (int n = 0; n < 16; n++) begin
      check("hist_twice", hist[n], 2);
      for (int b = 0; b < 5; b++) begin
        check("resil_half0", fixc[b][0][n], 1);
        check("resil_half1", fixc[b][1][n], 1);
      end
    end

    // gaps in IN_VALID
    step(1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 5'd16, 1'b0);
    step(1'b0, 1'b0, 5'd7, 1'b0);
    check("gap_hold", D_OUT, 4'hF);
    step(1'b0, 1'b0, 5'd9, 1'b0);
    check("gap_hold2", D_OUT, 4'hF);
    check("gap_ov", OUT_VALID, 1'b0);
    step(1'b0, 1'b1, 5'd5, 1'b0);
    check("gap_5F", BYTE_OUT, 8'h5F);

    // reset in the middle of a byte
    step(1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 5'd16, 1'b0);
    step(1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 5'd5, 1'b0);
    check("midrst_no_byte", BYTE_VALID, 1'b0);
    step(1'b0, 1'b1, 5'd21, 1'b0);
    check("midrst_A5", BYTE_OUT, 8'hA5);

    // random traffic with sparse resets
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 31)), 1'b0);

    step(1'b0, 1'b0, 5'd0, 1'b0);
    #5;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
